tdc_multi_fifo_reader: RTL and testbench
========================================

Name: tdc_multi_fifo_reader

Overview:
Parametrised successor to the single-chip TDC data reader. It services NUM_CH TDC result FIFOs, each with its own active-high empty flag, over one shared read bus (CSN/RDN/addr_out/data_in). Words are drained in bursts with round-robin channel arbitration and pushed, tagged with channel and address, into an internal output FIFO. AluTrigger pulses when a burst completes. A timeout flags channels that never report data.

Parameters:
NUM_CH, 2, number of TDC FIFOs / empty flags (1..8)
DATA_W, 28, TDC data bus width
ADDR_W, 4, TDC register address width
RDN_LOW, 2, RDN low time in clk cycles (>=1)
EF_SETTLE, 3, cycles after RDN rises before EF is re-evaluated (covers 2-flop sync)
MAX_WORDS, 8, maximum words read per burst (>=1)
TIMEOUT, 255, cycles to wait for any EF low before abort
OUT_DEPTH, 4, output FIFO depth (power of 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
read  in  1  burst request, 1-cycle pulse; ignored while busy
addr_in  in  ADDR_W  base TDC address, latched on accepted read
data_in  in  DATA_W  TDC data bus
EF  in  NUM_CH  per-channel empty flag (1=empty), asynchronous
CSN  out  1  TDC chip select, active low
RDN  out  1  TDC read strobe, active low
addr_out  out  ADDR_W  TDC address = base + channel (mod 2^ADDR_W)
data_out  out  DATA_W  output FIFO head data
ch_out  out  clog2(NUM_CH) (min 1)  channel tag of head word
addr_tag  out  ADDR_W  address tag of head word
out_valid  out  1  output FIFO non-empty
out_ready  in  1  consumer pop; pop occurs when out_valid&out_ready
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on timeout, cleared by next accepted read
AluTrigger  out  1  1-cycle pulse on normal burst completion

Behaviour:
- Reset values: CSN=1, RDN=1, addr_out=0, busy=0, timeout_err=0, AluTrigger=0, out_valid=0, data_out/ch_out/addr_tag=0, FIFO empty, RR pointer=0, state IDLE. Async reset mid-strobe returns RDN/CSN high immediately; the partial word is discarded.
- EF passes through a 2-flop synchronizer (reset value all-1 = empty). All decisions use the synced EF.
- States: IDLE -> WAIT_EF -> SETUP -> STROBE -> SETTLE -> (SETUP | DONE) -> IDLE; ABORT -> IDLE.
- IDLE: accepted read latches addr_in, clears timeout_err and the word count. Next state is WAIT_EF at cycle+1.
- WAIT_EF: a timer counts from 0. If any synced EF bit is 0, select a channel round-robin starting at RR pointer, then go to SETUP. If the timer reaches TIMEOUT with none low, go to ABORT. A word read earlier in the burst does not restart the timer for WAIT_EF re-entry; only the first entry waits.
- SETUP (1 cycle): addr_out=base+ch, CSN=0, RDN=1. If the output FIFO is full, stay in SETUP with CSN held low.
- STROBE: RDN=0 for RDN_LOW cycles. data_in is captured on the last low cycle and pushed {ch,addr,data} into the FIFO on the transition out. The word count increments.
- SETTLE: RDN=1, CSN=1 for EF_SETTLE cycles. Then:
  - if word count < MAX_WORDS and some synced EF is low, re-arbitrate and go to SETUP, with RR pointer = last ch+1 (mod NUM_CH);
  - else go to DONE.
- DONE: AluTrigger=1 for one cycle, then IDLE.
- ABORT: timeout_err=1, no AluTrigger, then IDLE.
- Minimum single-word burst from read pulse to AluTrigger: 1+2(sync)+1+RDN_LOW+EF_SETTLE+1 cycles.
- Output FIFO: simultaneous push and pop when full is allowed (pop frees the slot in the same cycle). Pop when empty has no effect. Data ordering is FIFO.
- A read pulse while busy is dropped. read coincident with the DONE cycle is dropped.

Decomposition:
- Package tdc_rd_pkg: state enum, function clog2, reset constants.
- One sub-module: tdc_out_fifo (parametrised sync FIFO, width DATA_W+ADDR_W+chW, depth OUT_DEPTH, show-ahead).
- Round-robin pick is a function in the package.

Test Plan:
1. NUM_CH=2, addr_in=4'h3, data_in=28'd1234. EF[0] falls 93 ns after read and rises 20 ns after RDN low. -> Exactly one RDN pulse (2 cycles) with addr_out=3, one FIFO word {ch0,3,1234}, and an AluTrigger pulse at the computed cycle.
2. EF[0] held low throughout, MAX_WORDS=8 -> exactly 8 strobes, 8 words, then AluTrigger. The 9th word is not read.
3. EF[0] and EF[1] both low for 4 words, addr_in=4'hF -> alternating channels 0,1,0,1 with addr_out F,0,F,0 (wrap).
4. No EF activity after read -> timeout_err=1 at cycle TIMEOUT+2 and no AluTrigger. The next read clears timeout_err.
5. out_ready=0 with OUT_DEPTH=4 and EF low -> 4 words stored, FSM holds in SETUP with RDN=1. Asserting out_ready resumes without loss or duplication.
6. Assert reset_n low during STROBE -> RDN=CSN=1 immediately and out_valid=0. After release, a new read completes normally.

Source files
------------

// File: rtl/tdc_rd_pkg.sv
// rtl/tdc_rd_pkg.sv - shared types, constants and helpers for the multi-FIFO TDC reader
package tdc_rd_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_EF, S_SETUP, S_STROBE, S_SETTLE, S_DONE, S_ABORT
   } state_t;

   localparam state_t RST_STATE = S_IDLE;
   localparam logic   RST_EF    = 1'b1;   // synchronizer powers up as "empty"

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

   // First requesting channel at or after ptr, wrapping at n (n <= 8).
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                          input int n);
      logic [2:0] pick;
      logic       found;
      logic [3:0] idx;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = 4'(ptr) + 4'(i);
         if (idx >= 4'(n)) idx = idx - 4'(n);
         if (i < n && !found && req[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/tdc_out_fifo.sv
// rtl/tdc_out_fifo.sv - show-ahead synchronous FIFO holding tagged TDC words
module tdc_out_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] wr_tdata,
   input  logic         wr_tvalid,
   output logic         wr_tready,
   output logic [W-1:0] rd_tdata,
   output logic         rd_tvalid,
   input  logic         rd_tready
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign rd_tvalid = (count != '0);
   assign wr_tready = (count != (AW+1)'(DEPTH));
   assign do_pop    = rd_tready && rd_tvalid;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign do_push   = wr_tvalid && (wr_tready || do_pop);
   assign rd_tdata  = rd_tvalid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_tdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tdc_multi_fifo_reader.sv
// rtl/tdc_multi_fifo_reader.sv - round-robin burst reader for NUM_CH TDC FIFOs on one shared read bus
module tdc_multi_fifo_reader
   import tdc_rd_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 28,
   parameter int ADDR_W    = 4,
   parameter int RDN_LOW   = 2,
   parameter int EF_SETTLE = 3,
   parameter int MAX_WORDS = 8,
   parameter int TIMEOUT   = 255,
   parameter int OUT_DEPTH = 4,
   localparam int CH_W     = clog2(NUM_CH)
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              read,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [NUM_CH-1:0] EF,
   output logic              CSN,
   output logic              RDN,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CH_W-1:0]   ch_out,
   output logic [ADDR_W-1:0] addr_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              timeout_err,
   output logic              AluTrigger
);
   localparam int TW = clog2(TIMEOUT + 1);
   localparam int SW = clog2(((RDN_LOW > EF_SETTLE) ? RDN_LOW : EF_SETTLE) + 1);
   localparam int WW = clog2(MAX_WORDS + 1);
   localparam int FW = CH_W + ADDR_W + DATA_W;

   state_t            state, state_nx;
   logic [NUM_CH-1:0] ef_s1, ef_s2;
   logic [ADDR_W-1:0] base_q;
   logic [CH_W-1:0]   ch_q, rr_ptr, pick;
   logic [TW-1:0]     timer;
   logic [SW-1:0]     sub_cnt;
   logic [WW-1:0]     word_cnt;
   logic [7:0]        req8;
   logic              any_low, strobe_last, settle_last, more, fifo_ready;
   logic [FW-1:0]     fifo_dout;

   always_comb begin
      req8 = '0;
      req8[NUM_CH-1:0] = ~ef_s2;
   end

   assign any_low     = |(~ef_s2);
   assign pick        = CH_W'(rr_pick(req8, 3'(rr_ptr), NUM_CH));
   assign strobe_last = (state == S_STROBE) && (sub_cnt == SW'(RDN_LOW - 1));
   assign settle_last = (state == S_SETTLE) && (sub_cnt == SW'(EF_SETTLE - 1));
   assign more        = (word_cnt < WW'(MAX_WORDS)) && any_low;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (read) state_nx = S_WAIT_EF;
         S_WAIT_EF: if (any_low) state_nx = S_SETUP;
                    else if (timer == TW'(TIMEOUT)) state_nx = S_ABORT;
         S_SETUP:   if (fifo_ready) state_nx = S_STROBE;
         S_STROBE:  if (strobe_last) state_nx = S_SETTLE;
         S_SETTLE:  if (settle_last) state_nx = more ? S_SETUP : S_DONE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RST_STATE;
         ef_s1       <= {NUM_CH{RST_EF}};
         ef_s2       <= {NUM_CH{RST_EF}};
         base_q      <= '0;
         ch_q        <= '0;
         rr_ptr      <= '0;
         timer       <= '0;
         sub_cnt     <= '0;
         word_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         ef_s1 <= EF;
         ef_s2 <= ef_s1;
         case (state)
            S_IDLE: if (read) begin
               base_q      <= addr_in;
               timeout_err <= 1'b0;
               word_cnt    <= '0;
               timer       <= '0;
            end
            S_WAIT_EF: if (any_low) ch_q <= pick;
                       else timer <= timer + 1'b1;
            S_STROBE: if (strobe_last) begin
               sub_cnt  <= '0;
               word_cnt <= word_cnt + 1'b1;
               rr_ptr   <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
            end else begin
               sub_cnt <= sub_cnt + 1'b1;
            end
            // rr_ptr was advanced at the end of the strobe, so pick is already fair here
            S_SETTLE: if (settle_last) begin
               sub_cnt <= '0;
               if (more) ch_q <= pick;
            end else begin
               sub_cnt <= sub_cnt + 1'b1;
            end
            S_ABORT: timeout_err <= 1'b1;
            default: ;
         endcase
      end
   end

   assign CSN        = !((state == S_SETUP) || (state == S_STROBE));
   assign RDN        = (state != S_STROBE);
   assign addr_out   = base_q + ADDR_W'(ch_q);
   assign busy       = (state != S_IDLE);
   assign AluTrigger = (state == S_DONE);

   tdc_out_fifo #(
      .W     (FW),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_tdata  ({ch_q, addr_out, data_in}),
      .wr_tvalid (strobe_last),
      .wr_tready (fifo_ready),
      .rd_tdata  (fifo_dout),
      .rd_tvalid (out_valid),
      .rd_tready (out_ready)
   );

   assign {ch_out, addr_tag, data_out} = fifo_dout;

endmodule

// File: tb/tb_tdc_multi_fifo_reader.sv
// tb/tb_tdc_multi_fifo_reader.sv - directed self-checking bench for tdc_multi_fifo_reader
module tb_tdc_multi_fifo_reader;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        read = 1'b0;
   logic [3:0]  addr_in = '0;
   logic [27:0] data_in;
   logic [1:0]  EF = 2'b11;
   logic        out_ready = 1'b1;
   logic        CSN, RDN, out_valid, busy, timeout_err, AluTrigger;
   logic [3:0]  addr_out, addr_tag;
   logic [27:0] data_out;
   logic [0:0]  ch_out;

   logic [27:0] data_base = '0;
   int          strobe_cnt = 0, alu_cnt = 0, alu_cyc = 0, cyc = 0;
   int          n_checks = 0, n_fail = 0, rdn_low_len = 0;
   int          pulse_len[$];
   logic [3:0]  strobe_addr[$];
   logic [32:0] words[$];
   logic        rdn_prev = 1'b1;

   // every strobe sees a distinct data word: data_base + strobe index
   assign data_in = data_base + 28'(strobe_cnt);

   tdc_multi_fifo_reader dut (
      .clk(clk), .reset_n(reset_n), .read(read), .addr_in(addr_in), .data_in(data_in),
      .EF(EF), .CSN(CSN), .RDN(RDN), .addr_out(addr_out), .data_out(data_out),
      .ch_out(ch_out), .addr_tag(addr_tag), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .timeout_err(timeout_err), .AluTrigger(AluTrigger)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!RDN && rdn_prev) begin
         strobe_cnt++;
         strobe_addr.push_back(addr_out);
         rdn_low_len = 1;
      end else if (!RDN) begin
         rdn_low_len++;
      end
      if (RDN && !rdn_prev) pulse_len.push_back(rdn_low_len);
      if (AluTrigger === 1'b1) begin
         alu_cnt++;
         alu_cyc = cyc;
      end
      if (out_valid === 1'b1 && out_ready) words.push_back({ch_out, addr_tag, data_out});
      rdn_prev = RDN;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic pulse_read(input logic [3:0] a);
      @(posedge clk); #1;
      read = 1'b1;
      addr_in = a;
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int i;
      i = 0;
      while (busy !== 1'b0 && i < 2000) begin
         @(posedge clk); #1;
         i++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic wait_strobes(input int target, output bit ok);
      int i;
      i = 0;
      while (strobe_cnt < target && i < 500) begin
         @(posedge clk); #1;
         i++;
      end
      ok = (strobe_cnt >= target);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (CSN !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b expected 1", CSN); end
      n_checks++; if (RDN !== 1'b1) begin n_fail++; $display("FAIL reset_rdn: got %b expected 1", RDN); end
      n_checks++; if (addr_out !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr_out); end
      n_checks++; if ({busy, timeout_err, AluTrigger, out_valid} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, timeout_err, AluTrigger, out_valid});
      end
      n_checks++; if ({ch_out, addr_tag, data_out} !== 33'h0) begin
         n_fail++; $display("FAIL reset_head: got %h expected 0", {ch_out, addr_tag, data_out});
      end
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if ({busy, CSN, RDN} !== 3'b011) begin
         n_fail++; $display("FAIL reset_idle: got %b expected 011", {busy, CSN, RDN});
      end
   endtask

   task automatic test_alternate();
      int s0, a0;
      bit ok, ok2;
      logic [32:0] exp_w, got_w;
      logic [3:0]  exp_a, got_a;
      s0 = strobe_cnt; a0 = alu_cnt;
      words.delete(); strobe_addr.delete();
      data_base = 28'h0100000;
      EF = 2'b00;
      pulse_read(4'hF);
      wait_strobes(s0 + 4, ok);
      EF = 2'b11;
      wait_idle(ok2);
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL alt_done: got %b expected 11", {ok, ok2}); end
      n_checks++; if (strobe_cnt - s0 != 4) begin n_fail++; $display("FAIL alt_strobes: got %0d expected 4", strobe_cnt - s0); end
      n_checks++; if (alu_cnt - a0 != 1) begin n_fail++; $display("FAIL alt_alu: got %0d expected 1", alu_cnt - a0); end
      for (int k = 0; k < 4; k++) begin
         exp_a = k[0] ? 4'h0 : 4'hF;
         exp_w = {k[0], exp_a, data_base + 28'(s0 + k + 1)};
         got_w = (words.size() > k) ? words[k] : 'x;
         got_a = (strobe_addr.size() > k) ? strobe_addr[k] : 'x;
         n_checks++; if (got_w !== exp_w) begin n_fail++; $display("FAIL alt_word%0d: got %h expected %h", k, got_w, exp_w); end
         n_checks++; if (got_a !== exp_a) begin n_fail++; $display("FAIL alt_addr%0d: got %h expected %h", k, got_a, exp_a); end
      end
   endtask

   task automatic test_single();
      int s0, a0, acc;
      bit ok;
      logic [32:0] got_w;
      s0 = strobe_cnt; a0 = alu_cnt;
      words.delete(); strobe_addr.delete(); pulse_len.delete();
      data_base = 28'(1234 - strobe_cnt - 1);
      EF = 2'b11;
      pulse_read(4'h3);
      acc = cyc;
      #83 EF[0] = 1'b0;
      for (int i = 0; i < 1000 && RDN !== 1'b0; i++) #1;
      #20 EF[0] = 1'b1;
      wait_idle(ok);
      repeat (3) @(posedge clk);
      #1;
      got_w = (words.size() > 0) ? words[0] : 'x;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_idle: got busy %b expected 0", busy); end
      n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - s0); end
      n_checks++; if (pulse_len.size() != 1 || pulse_len[0] != 2) begin
         n_fail++; $display("FAIL single_rdn_width: got %0d pulses expected one of 2 cycles", pulse_len.size());
      end
      n_checks++; if (strobe_addr.size() != 1 || strobe_addr[0] !== 4'h3) begin
         n_fail++; $display("FAIL single_addr: got %0d strobes expected one at 3", strobe_addr.size());
      end
      n_checks++; if (words.size() != 1 || got_w !== {1'b0, 4'h3, 28'd1234}) begin
         n_fail++; $display("FAIL single_word: got %h (n=%0d) expected %h", got_w, words.size(), {1'b0, 4'h3, 28'd1234});
      end
      n_checks++; if (alu_cnt - a0 != 1) begin n_fail++; $display("FAIL single_alu: got %0d expected 1", alu_cnt - a0); end
      n_checks++; if (alu_cyc - acc != 17) begin n_fail++; $display("FAIL single_alu_cycle: got %0d expected 17", alu_cyc - acc); end
   endtask

   task automatic test_burst();
      int s0, a0, n2;
      bit ok, ok2;
      logic [32:0] exp_w, got_w;
      s0 = strobe_cnt; a0 = alu_cnt;
      words.delete(); pulse_len.delete();
      data_base = 28'h0200000;
      EF = 2'b10;
      pulse_read(4'h5);
      wait_strobes(s0 + 2, ok);
      pulse_read(4'h9);
      wait_idle(ok2);
      repeat (20) @(posedge clk);
      #1;
      EF = 2'b11;
      n2 = 0;
      foreach (pulse_len[i]) if (pulse_len[i] == 2) n2++;
      n_checks++; if (!(ok && ok2) || busy !== 1'b0) begin n_fail++; $display("FAIL burst_idle: got busy %b expected 0", busy); end
      n_checks++; if (strobe_cnt - s0 != 8) begin n_fail++; $display("FAIL burst_strobes: got %0d expected 8", strobe_cnt - s0); end
      n_checks++; if (n2 != 8) begin n_fail++; $display("FAIL burst_rdn_width: got %0d expected 8", n2); end
      n_checks++; if (words.size() != 8) begin n_fail++; $display("FAIL burst_count: got %0d expected 8", words.size()); end
      n_checks++; if (alu_cnt - a0 != 1) begin n_fail++; $display("FAIL burst_alu: got %0d expected 1", alu_cnt - a0); end
      for (int k = 0; k < 8; k++) begin
         exp_w = {1'b0, 4'h5, data_base + 28'(s0 + k + 1)};
         got_w = (words.size() > k) ? words[k] : 'x;
         n_checks++; if (got_w !== exp_w) begin n_fail++; $display("FAIL burst_word%0d: got %h expected %h", k, got_w, exp_w); end
      end
   endtask

   task automatic test_timeout();
      int s0, a0, acc, i;
      bit ok, ok2;
      s0 = strobe_cnt; a0 = alu_cnt;
      words.delete();
      EF = 2'b11;
      pulse_read(4'h7);
      acc = cyc;
      i = 0;
      while (timeout_err !== 1'b1 && i < 400) begin
         @(posedge clk); #1;
         i++;
      end
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1", timeout_err); end
      n_checks++; if (cyc - acc != TIMEOUT + 2) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", cyc - acc, TIMEOUT + 2); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
      n_checks++; if (alu_cnt != a0 || strobe_cnt != s0) begin
         n_fail++; $display("FAIL timeout_quiet: got alu %0d strobes %0d expected 0 0", alu_cnt - a0, strobe_cnt - s0);
      end
      pulse_read(4'h7);
      n_checks++; if ({timeout_err, busy} !== 2'b01) begin n_fail++; $display("FAIL timeout_clear: got %b expected 01", {timeout_err, busy}); end
      EF = 2'b10;
      wait_strobes(s0 + 1, ok);
      EF = 2'b11;
      wait_idle(ok2);
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (!(ok && ok2) || alu_cnt - a0 != 1 || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_recover: got alu %0d err %b expected 1 0", alu_cnt - a0, timeout_err);
      end
      n_checks++; if (words.size() != 1) begin n_fail++; $display("FAIL timeout_words: got %0d expected 1", words.size()); end
   endtask

   task automatic test_backpressure();
      int s0, a0;
      bit ok;
      logic [32:0] exp_w, got_w;
      s0 = strobe_cnt; a0 = alu_cnt;
      words.delete();
      data_base = 28'h0300000;
      out_ready = 1'b0;
      EF = 2'b10;
      pulse_read(4'h2);
      repeat (40) @(posedge clk);
      #1;
      n_checks++; if (strobe_cnt - s0 != 4) begin n_fail++; $display("FAIL bp_strobes: got %0d expected 4", strobe_cnt - s0); end
      n_checks++; if ({busy, CSN, RDN, out_valid} !== 4'b1011) begin
         n_fail++; $display("FAIL bp_hold: got %b expected 1011", {busy, CSN, RDN, out_valid});
      end
      n_checks++; if (data_out !== data_base + 28'(s0 + 1)) begin
         n_fail++; $display("FAIL bp_head: got %h expected %h", data_out, data_base + 28'(s0 + 1));
      end
      out_ready = 1'b1;
      wait_idle(ok);
      repeat (3) @(posedge clk);
      #1;
      EF = 2'b11;
      n_checks++; if (!ok || strobe_cnt - s0 != 8) begin n_fail++; $display("FAIL bp_strobes_total: got %0d expected 8", strobe_cnt - s0); end
      n_checks++; if (words.size() != 8 || alu_cnt - a0 != 1) begin
         n_fail++; $display("FAIL bp_count: got %0d words %0d alu expected 8 1", words.size(), alu_cnt - a0);
      end
      for (int k = 0; k < 8; k++) begin
         exp_w = {1'b0, 4'h2, data_base + 28'(s0 + k + 1)};
         got_w = (words.size() > k) ? words[k] : 'x;
         n_checks++; if (got_w !== exp_w) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", k, got_w, exp_w); end
      end
   endtask

   task automatic test_reset_mid_strobe();
      int s0, a0, i;
      bit ok;
      logic [32:0] exp_w, got_w;
      s0 = strobe_cnt;
      out_ready = 1'b0;
      data_base = 28'h0400000;
      EF = 2'b10;
      pulse_read(4'h6);
      i = 0;
      while ((strobe_cnt - s0 < 3 || RDN !== 1'b0) && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      n_checks++; if (RDN !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL mid_setup: got rdn %b valid %b expected 0 1", RDN, out_valid);
      end
      reset_n = 1'b0;
      #1;
      n_checks++; if ({RDN, CSN, out_valid, busy} !== 4'b1100) begin
         n_fail++; $display("FAIL mid_reset: got %b expected 1100", {RDN, CSN, out_valid, busy});
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      words.delete();
      s0 = strobe_cnt; a0 = alu_cnt;
      pulse_read(4'h6);
      wait_idle(ok);
      repeat (3) @(posedge clk);
      #1;
      EF = 2'b11;
      n_checks++; if (!ok || alu_cnt - a0 != 1 || strobe_cnt - s0 != 8) begin
         n_fail++; $display("FAIL mid_rerun: got alu %0d strobes %0d expected 1 8", alu_cnt - a0, strobe_cnt - s0);
      end
      for (int k = 0; k < 8; k += 7) begin
         exp_w = {1'b0, 4'h6, data_base + 28'(s0 + k + 1)};
         got_w = (words.size() > k) ? words[k] : 'x;
         n_checks++; if (got_w !== exp_w || words.size() != 8) begin
            n_fail++; $display("FAIL mid_word%0d: got %h (n=%0d) expected %h", k, got_w, words.size(), exp_w);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_single();
      test_burst();
      test_timeout();
      test_backpressure();
      test_reset_mid_strobe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
